// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer for the 8-bit core: walks each instruction through
// fetch, PC increment pairs, operand fetch and jump resolution.
module pc_sequencer (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       run,
  input  logic       halt_req,
  input  logic [7:0] DBUS,
  input  logic       zf,
  input  logic       cf,
  output logic       MEM_RD,
  output logic       LDPC,
  output logic       LOAD,
  output logic [7:0] load_addr,
  output logic [7:0] IR,
  output logic       EXEC,
  output logic       busy,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_INC1   = 4'd3,
    S_INC2   = 4'd4,
    S_DECODE = 4'd5,
    S_EXEC   = 4'd6,
    S_OFETCH = 4'd7,
    S_OLATCH = 4'd8,
    S_OINC1  = 4'd9,
    S_OINC2  = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;
  logic       mem_rd_q, mem_rd_d;
  logic       ldpc_q, ldpc_d;
  logic       load_q, load_d;
  logic       exec_q, exec_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       taken_s;

  // Branch condition for the opcode held in IR, using the flags as seen at OLATCH.
  always_comb begin
    taken_s = 1'b0;
    case (ir_q[7:4])
      OP_JMP:  taken_s = 1'b1;
      OP_JZ:   taken_s = zf;
      OP_JC:   taken_s = cf;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state and datapath latch selection.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = DBUS;
        state_d = S_INC1;
      end
      S_INC1:  state_d = S_INC2;
      S_INC2:  state_d = S_DECODE;
      S_DECODE: begin
        case (ir_q[7:4])
          OP_HLT:               state_d = S_HALT;
          OP_JMP, OP_JZ, OP_JC: state_d = S_OFETCH;
          default:              state_d = S_EXEC;
        endcase
      end
      S_OFETCH: state_d = S_OLATCH;
      S_OLATCH: begin
        operand_d = DBUS;
        if (taken_s) state_d = S_JUMP;
        else         state_d = S_OINC1;
      end
      S_OINC1: state_d = S_OINC2;
      // Instruction boundaries: the only places halt_req is honoured.
      S_EXEC, S_JUMP, S_OINC2: begin
        if (halt_req) state_d = S_IDLE;
        else          state_d = S_FETCH;
      end
      S_HALT: begin
        if (!run) state_d = S_HALT == S_HALT ? S_IDLE : S_IDLE;
        else      state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mem_rd_d = (state_d == S_FETCH) || (state_d == S_OFETCH);
    ldpc_d   = (state_d == S_INC1)  || (state_d == S_INC2) ||
               (state_d == S_OINC1) || (state_d == S_OINC2);
    load_d   = (state_d == S_JUMP);
    exec_d   = (state_d == S_EXEC);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State, instruction/operand registers and registered strobes.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= S_IDLE;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
      mem_rd_q  <= 1'b0;
      ldpc_q    <= 1'b0;
      load_q    <= 1'b0;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      mem_rd_q  <= mem_rd_d;
      ldpc_q    <= ldpc_d;
      load_q    <= load_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign state     = state_q;
  assign IR        = ir_q;
  assign load_addr = operand_q;
  assign MEM_RD    = mem_rd_q;
  assign LDPC      = ldpc_q;
  assign LOAD      = load_q;
  assign EXEC      = exec_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small PC/memory environment model
// and a monitor on the LDPC pairing and LOAD/LDPC exclusion rules.
module tb_pc_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       run;
  logic       halt_req;
  logic [7:0] dbus;
  logic       zf;
  logic       cf;
  logic       MEM_RD, LDPC, LOAD, EXEC, busy, halted;
  logic [7:0] load_addr, IR;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];
  logic [7:0] pc_m;
  logic       half_m;
  int         ldpc_run = 0;
  int         ldpc_bad_runs = 0;
  int         overlap = 0;

  // Packed view: state, MEM_RD, LDPC, LOAD, EXEC, busy, halted
  wire [9:0] obs_s = {state, MEM_RD, LDPC, LOAD, EXEC, busy, halted};

  localparam logic [9:0] E_IDLE   = {4'd0,  6'b000000};
  localparam logic [9:0] E_FETCH  = {4'd1,  6'b100010};
  localparam logic [9:0] E_LATCH  = {4'd2,  6'b000010};
  localparam logic [9:0] E_INC1   = {4'd3,  6'b010010};
  localparam logic [9:0] E_INC2   = {4'd4,  6'b010010};
  localparam logic [9:0] E_DEC    = {4'd5,  6'b000010};
  localparam logic [9:0] E_EXEC   = {4'd6,  6'b000110};
  localparam logic [9:0] E_OFETCH = {4'd7,  6'b100010};
  localparam logic [9:0] E_OLATCH = {4'd8,  6'b000010};
  localparam logic [9:0] E_OINC1  = {4'd9,  6'b010010};
  localparam logic [9:0] E_OINC2  = {4'd10, 6'b010010};
  localparam logic [9:0] E_JUMP   = {4'd11, 6'b001010};
  localparam logic [9:0] E_HALT   = {4'd12, 6'b000001};

  pc_sequencer dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .run       (run),
    .halt_req  (halt_req),
    .DBUS      (dbus),
    .zf        (zf),
    .cf        (cf),
    .MEM_RD    (MEM_RD),
    .LDPC      (LDPC),
    .LOAD      (LOAD),
    .load_addr (load_addr),
    .IR        (IR),
    .EXEC      (EXEC),
    .busy      (busy),
    .halted    (halted),
    .state     (state)
  );

  always #5 sys_clk = ~sys_clk;

  // PC counter and synchronous-read memory seen by the sequencer.
  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc_m   <= 8'h00;
      half_m <= 1'b0;
      dbus   <= 8'h00;
    end else begin
      if (MEM_RD) dbus <= mem[pc_m];
      if (LOAD) begin
        pc_m   <= load_addr;
        half_m <= 1'b0;
      end else if (LDPC) begin
        if (half_m) pc_m <= pc_m + 8'd1;
        half_m <= ~half_m;
      end else begin
        half_m <= 1'b0;
      end
    end
  end

  // LDPC run lengths must be exactly two; reset may cut a run short.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      ldpc_run <= 0;
    end else if (LDPC) begin
      ldpc_run <= ldpc_run + 1;
    end else begin
      if (ldpc_run != 0 && ldpc_run != 2) ldpc_bad_runs <= ldpc_bad_runs + 1;
      ldpc_run <= 0;
    end
    if (sys_rst && LDPC && LOAD) overlap <= overlap + 1;
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    run      = 1'b0;
    halt_req = 1'b0;
    zf       = 1'b0;
    cf       = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 sys_rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs_s !== E_IDLE) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs_s, E_IDLE);
    end
    total++;
    if (IR !== 8'h00) begin
      bad++; $display("FAIL reset_ir got=%h want=00", IR);
    end
    total++;
    if (load_addr !== 8'h00) begin
      bad++; $display("FAIL reset_load_addr got=%h want=00", load_addr);
    end
    tick(); tick();
    total++;
    if (obs_s !== E_IDLE) begin
      bad++; $display("FAIL idle_without_run got=%h want=%h", obs_s, E_IDLE);
    end
  endtask

  task automatic test_single();
    logic [9:0] exp [0:6];
    exp = '{E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_EXEC, E_FETCH};
    apply_reset();
    mem[0] = 8'h12;
    run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      total++;
      if (obs_s !== exp[c]) begin
        bad++; $display("FAIL single c%0d got=%h want=%h", c + 1, obs_s, exp[c]);
      end
      if (c == 4) begin
        total++;
        if (IR !== 8'h12) begin
          bad++; $display("FAIL single_ir got=%h want=12", IR);
        end
      end
    end
  endtask

  task automatic test_jmp();
    logic [9:0] exp [0:10];
    exp = '{E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_OFETCH, E_OLATCH,
            E_JUMP, E_FETCH, E_LATCH, E_INC1};
    apply_reset();
    mem[0]     = 8'hA0;
    mem[1]     = 8'h40;
    mem[8'h40] = 8'h5C;
    run = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      total++;
      if (obs_s !== exp[c]) begin
        bad++; $display("FAIL jmp c%0d got=%h want=%h", c + 1, obs_s, exp[c]);
      end
      if (c == 7) begin
        total++;
        if (load_addr !== 8'h40) begin
          bad++; $display("FAIL jmp_load_addr got=%h want=40", load_addr);
        end
      end
      if (c == 10) begin
        total++;
        if (IR !== 8'h5C) begin
          bad++; $display("FAIL jmp_target_ir got=%h want=5c", IR);
        end
      end
    end
  endtask

  task automatic test_cond_jumps();
    logic [9:0] exp [0:27];
    exp = '{E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_OFETCH, E_OLATCH,
            E_OINC1, E_OINC2,
            E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_OFETCH, E_OLATCH, E_JUMP,
            E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_OFETCH, E_OLATCH, E_JUMP,
            E_FETCH, E_LATCH, E_INC1};
    apply_reset();
    mem[0]     = 8'hB0;
    mem[1]     = 8'h55;
    mem[2]     = 8'hB0;
    mem[3]     = 8'h55;
    mem[8'h55] = 8'hC0;
    mem[8'h56] = 8'h66;
    mem[8'h66] = 8'h21;
    zf  = 1'b0;
    cf  = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 28; c++) begin
      tick();
      total++;
      if (obs_s !== exp[c]) begin
        bad++; $display("FAIL cond c%0d got=%h want=%h", c + 1, obs_s, exp[c]);
      end
      if (c == 7) begin
        total++;
        if (load_addr !== 8'h55) begin
          bad++; $display("FAIL jz_nt_load_addr got=%h want=55", load_addr);
        end
      end
      if (c == 9) begin
        zf = 1'b1;
        cf = 1'b0;
      end
      if (c == 16) begin
        total++;
        if (load_addr !== 8'h55) begin
          bad++; $display("FAIL jz_t_load_addr got=%h want=55", load_addr);
        end
      end
      if (c == 17) begin
        zf = 1'b0;
        cf = 1'b1;
      end
      if (c == 24) begin
        total++;
        if (load_addr !== 8'h66) begin
          bad++; $display("FAIL jc_t_load_addr got=%h want=66", load_addr);
        end
      end
      if (c == 27) begin
        total++;
        if (IR !== 8'h21) begin
          bad++; $display("FAIL jc_target_ir got=%h want=21", IR);
        end
      end
    end
  endtask

  task automatic test_hlt();
    logic [9:0] exp [0:10];
    exp = '{E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_HALT, E_HALT,
            E_HALT, E_HALT, E_IDLE, E_FETCH};
    apply_reset();
    mem[0] = 8'hF0;
    run = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      total++;
      if (obs_s !== exp[c]) begin
        bad++; $display("FAIL hlt c%0d got=%h want=%h", c + 1, obs_s, exp[c]);
      end
      if (c == 5) begin
        total++;
        if (IR !== 8'hF0) begin
          bad++; $display("FAIL hlt_ir got=%h want=f0", IR);
        end
      end
      if (c == 8) run = 1'b0;
      if (c == 9) run = 1'b1;
    end
  endtask

  task automatic test_halt_req();
    logic [9:0] exp [0:8];
    exp = '{E_FETCH, E_LATCH, E_INC1, E_INC2, E_DEC, E_EXEC, E_IDLE,
            E_IDLE, E_IDLE};
    apply_reset();
    mem[0] = 8'h30;
    run = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      total++;
      if (obs_s !== exp[c]) begin
        bad++; $display("FAIL halt_req c%0d got=%h want=%h", c + 1, obs_s, exp[c]);
      end
      if (c == 0) halt_req = 1'b1;
      if (c == 6) run = 1'b0;
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem[0]     = 8'hA0;
    mem[1]     = 8'h40;
    mem[8'h40] = 8'h12;
    run = 1'b1;
    for (int c = 0; c < 11; c++) tick();
    total++;
    if (obs_s !== E_INC1) begin
      bad++; $display("FAIL mid_pre_reset got=%h want=%h", obs_s, E_INC1);
    end
    #2 sys_rst = 1'b0;
    #1;
    total++;
    if (obs_s !== E_IDLE) begin
      bad++; $display("FAIL mid_reset_outputs got=%h want=%h", obs_s, E_IDLE);
    end
    total++;
    if ({IR, load_addr} !== 16'h0000) begin
      bad++; $display("FAIL mid_reset_regs got=%h want=0000", {IR, load_addr});
    end
    @(negedge sys_clk);
    #1 sys_rst = 1'b1;
    tick();
    total++;
    if (obs_s !== E_FETCH) begin
      bad++; $display("FAIL mid_restart got=%h want=%h", obs_s, E_FETCH);
    end
    tick(); tick();
    total++;
    if (IR !== 8'hA0) begin
      bad++; $display("FAIL mid_restart_ir got=%h want=a0", IR);
    end
  endtask

  task automatic test_ldpc_pairs();
    tick();
    total++;
    if (ldpc_bad_runs !== 0) begin
      bad++; $display("FAIL ldpc_pairing got=%0d want=0", ldpc_bad_runs);
    end
    total++;
    if (overlap !== 0) begin
      bad++; $display("FAIL load_ldpc_overlap got=%0d want=0", overlap);
    end
  endtask

  initial begin
    sys_rst  = 1'b0;
    run      = 1'b0;
    halt_req = 1'b0;
    zf       = 1'b0;
    cf       = 1'b0;
    test_reset();
    test_single();
    test_jmp();
    test_cond_jumps();
    test_hlt();
    test_halt_req();
    test_reset_mid();
    test_ldpc_pairs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
